// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Queue entries are sized for the widest supported PC/instruction (64 bits).
package fetch_pkg;

    localparam int FETCH_MAX_W = 64;

    localparam logic [FETCH_MAX_W-1:0] FETCH_NOP      = '0;
    localparam logic [FETCH_MAX_W-1:0] FETCH_RESET_PC = '0;

    typedef struct packed {
        logic [FETCH_MAX_W-1:0] pc;
        logic [FETCH_MAX_W-1:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode handshake bundle; the fetch side is the master.
interface fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INSN_W = 32
);
    logic              fd_valid;
    logic [ADDR_W-1:0] fd_pc;
    logic [INSN_W-1:0] fd_ir;
    logic              fd_ready;

    modport master (output fd_valid, output fd_pc, output fd_ir, input fd_ready);
    modport slave  (input fd_valid, input fd_pc, input fd_ir, output fd_ready);
endinterface

// File: rtl/fetch_queue.sv
// Circular buffer of fetched {pc, ir} entries; clear wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t push_data,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(QDEPTH);

    fetch_entry_t     mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, redirect handling and a small fetch queue.
// Define FETCH_PERF_EN to add the perf_fetched/perf_stalls counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSN_W   = 32,
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_imem,
    input  logic [INSN_W-1:0] q_imem,
    fetch_if.master           fd,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalls
`endif
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic              q_full;
    logic              q_empty;
    logic              dequeue;
    logic              do_fetch;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic              unused_head;

    assign address_imem = pc;
    assign pc_plus1     = pc + ADDR_W'(1);
    assign dequeue      = fd.fd_valid & fd.fd_ready;
    assign do_fetch     = !redirect & (!q_full | dequeue);
    assign unused_head  = ^head;

    always_comb begin
        push_entry    = '0;
        push_entry.pc = FETCH_MAX_W'(pc_plus1);
        push_entry.ir = FETCH_MAX_W'(q_imem);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)          pc <= RESET_PC;
        else if (redirect)  pc <= redirect_pc;
        else if (do_fetch)  pc <= pc_plus1;
    end

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (do_fetch),
        .pop       (dequeue & !redirect),
        .clear     (redirect),
        .push_data (push_entry),
        .full      (q_full),
        .empty     (q_empty),
        .head      (head)
    );

    // Decode sees only registered queue state, forced to a NOP when empty.
    always_comb begin
        fd.fd_valid = !q_empty;
        fd.fd_pc    = '0;
        fd.fd_ir    = INSN_W'(FETCH_NOP);
        if (!q_empty) begin
            fd.fd_pc = head.pc[ADDR_W-1:0];
            fd.fd_ir = head.ir[INSN_W-1:0];
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (do_fetch)                   perf_fetched <= perf_fetched + 32'd1;
            if (fd.fd_valid && !fd.fd_ready) perf_stalls  <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 32-bit instance plus a 4-bit-PC instance for wrap.
// Instruction memory model: imem[k] = k + 100.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] address_imem;
    logic [31:0] q_imem;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [3:0]  address_imem4;
    logic [31:0] q_imem4;
    logic        redirect4;
    logic [3:0]  redirect_pc4;
    int          total;
    int          bad;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
    logic [31:0] perf_fetched4;
    logic [31:0] perf_stalls4;
`endif

    fetch_if #(.ADDR_W(32), .INSN_W(32)) fd_bus ();
    fetch_if #(.ADDR_W(4),  .INSN_W(32)) fd_bus4 ();

    fetch_unit #(.ADDR_W(32), .INSN_W(32), .QDEPTH(2), .RESET_PC(32'd0)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_imem (address_imem),
        .q_imem       (q_imem),
        .fd           (fd_bus.master),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stalls  (perf_stalls)
`endif
    );

    fetch_unit #(.ADDR_W(4), .INSN_W(32), .QDEPTH(2), .RESET_PC(4'd0)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .address_imem (address_imem4),
        .q_imem       (q_imem4),
        .fd           (fd_bus4.master),
        .redirect     (redirect4),
        .redirect_pc  (redirect_pc4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched4),
        .perf_stalls  (perf_stalls4)
`endif
    );

    assign q_imem  = address_imem + 32'd100;
    assign q_imem4 = 32'(address_imem4) + 32'd100;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
        fd_bus.fd_ready = rdy;
        redirect        = redir;
        redirect_pc     = rpc;
        @(posedge clock);
        #1;
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b1;
        fd_bus.fd_ready = 1'b1;
        redirect        = 1'b0;
        redirect_pc     = '0;
        fd_bus4.fd_ready = 1'b1;
        redirect4       = 1'b0;
        redirect_pc4    = '0;

        @(posedge clock);
        #1;
        checkOutput("rst_valid", 64'(fd_bus.fd_valid), 64'd0);
        checkOutput("rst_pc",    64'(fd_bus.fd_pc),    64'd0);
        checkOutput("rst_ir",    64'(fd_bus.fd_ir),    64'd0);
        checkOutput("rst_addr",  64'(address_imem),    64'd0);
        checkOutput("rst_addr4", 64'(address_imem4),   64'd0);
        reset = 1'b0;
        #1;
        checkOutput("rel_addr", 64'(address_imem), 64'd0);

        // Streaming with decode always ready: one instruction per cycle.
        for (int n = 1; n <= 3; n++) begin
            applyStimulus(1'b1, 1'b0, 32'd0);
            checkOutput("stream_valid", 64'(fd_bus.fd_valid), 64'd1);
            checkOutput("stream_pc",    64'(fd_bus.fd_pc),    64'(n));
            checkOutput("stream_ir",    64'(fd_bus.fd_ir),    64'(n + 99));
            checkOutput("stream_addr",  64'(address_imem),    64'(n));
        end

        // Decode stalled from reset: the queue fills and the PC holds.
        fd_bus.fd_ready = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("rst2_valid", 64'(fd_bus.fd_valid), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("full_addr",  64'(address_imem),    64'd2);
        checkOutput("full_pc",    64'(fd_bus.fd_pc),    64'd1);
        checkOutput("full_ir",    64'(fd_bus.fd_ir),    64'd100);
        checkOutput("full_valid", 64'(fd_bus.fd_valid), 64'd1);

        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("swap_pc",   64'(fd_bus.fd_pc), 64'd2);
        checkOutput("swap_ir",   64'(fd_bus.fd_ir), 64'd101);
        checkOutput("swap_addr", 64'(address_imem), 64'd3);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("hold_addr", 64'(address_imem), 64'd3);
        checkOutput("hold_pc",   64'(fd_bus.fd_pc), 64'd2);

        // Redirect flushes stale entries and restarts at the target.
        applyStimulus(1'b1, 1'b1, 32'h40);
        checkOutput("redir_addr",  64'(address_imem),    64'h40);
        checkOutput("redir_valid", 64'(fd_bus.fd_valid), 64'd0);
        checkOutput("redir_pc",    64'(fd_bus.fd_pc),    64'd0);
        checkOutput("redir_ir",    64'(fd_bus.fd_ir),    64'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("tgt_valid", 64'(fd_bus.fd_valid), 64'd1);
        checkOutput("tgt_pc",    64'(fd_bus.fd_pc),    64'h41);
        checkOutput("tgt_ir",    64'(fd_bus.fd_ir),    64'hA4);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("tgt_full_addr", 64'(address_imem), 64'h42);
        checkOutput("tgt_full_pc",   64'(fd_bus.fd_pc), 64'h41);

        // Mid-cycle reset with a full queue.
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_valid", 64'(fd_bus.fd_valid), 64'd0);
        checkOutput("midrst_pc",    64'(fd_bus.fd_pc),    64'd0);
        checkOutput("midrst_ir",    64'(fd_bus.fd_ir),    64'd0);
        checkOutput("midrst_addr",  64'(address_imem),    64'd0);
`ifdef FETCH_PERF_EN
        checkOutput("midrst_fetched", 64'(perf_fetched), 64'd0);
        checkOutput("midrst_stalls",  64'(perf_stalls),  64'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rel2_addr", 64'(address_imem), 64'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("rel2_pc", 64'(fd_bus.fd_pc), 64'd1);
`ifdef FETCH_PERF_EN
        checkOutput("perf_fetched1", 64'(perf_fetched), 64'd1);
        checkOutput("perf_stalls1",  64'(perf_stalls),  64'd0);
`endif
        applyStimulus(1'b0, 1'b0, 32'd0);
`ifdef FETCH_PERF_EN
        checkOutput("perf_fetched2", 64'(perf_fetched), 64'd2);
        checkOutput("perf_stalls2",  64'(perf_stalls),  64'd1);
`endif

        // 4-bit PC wraps from 15 back to 0.
        redirect4    = 1'b1;
        redirect_pc4 = 4'd14;
        @(posedge clock);
        #1;
        checkOutput("w4_redir_addr",  64'(address_imem4),    64'd14);
        checkOutput("w4_redir_valid", 64'(fd_bus4.fd_valid), 64'd0);
        redirect4 = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("w4_addr15", 64'(address_imem4), 64'd15);
        checkOutput("w4_pc15",   64'(fd_bus4.fd_pc), 64'd15);
        checkOutput("w4_ir15",   64'(fd_bus4.fd_ir), 64'd114);
        @(posedge clock);
        #1;
        checkOutput("w4_addr0", 64'(address_imem4), 64'd0);
        checkOutput("w4_pc0",   64'(fd_bus4.fd_pc), 64'd0);
        checkOutput("w4_ir0",   64'(fd_bus4.fd_ir), 64'd115);
        @(posedge clock);
        #1;
        checkOutput("w4_addr1", 64'(address_imem4), 64'd1);
        checkOutput("w4_pc1",   64'(fd_bus4.fd_pc), 64'd1);
        checkOutput("w4_ir1",   64'(fd_bus4.fd_ir), 64'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, 32, PC/imem address width.
REQ-002 SHALL have parameter INSN_W, 32, instruction width.
REQ-003 SHALL have parameter QDEPTH, 2, fetch-queue entries; power of two, >=2.
REQ-004 SHALL have parameter RESET_PC, 0, PC value after reset.
REQ-005 SHALL have port clock  in  1  the single clock; all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port address_imem  out  ADDR_W  current PC, driven straight from the PC register.
REQ-008 SHALL have port q_imem  in  INSN_W  instruction at address_imem, valid in the same cycle.
REQ-009 SHALL have port fd_valid  out  1  queue head holds an instruction.
REQ-010 SHALL have port fd_pc  out  ADDR_W  head fetch address + 1 (next-PC convention).
REQ-011 SHALL have port fd_ir  out  INSN_W  head instruction; NOP (all zero) when fd_valid=0.
REQ-012 SHALL have port fd_ready  in  1  decode accepts head this cycle.
REQ-013 SHALL have port redirect  in  1  branch/jump/flush request.
REQ-014 SHALL have port redirect_pc  in  ADDR_W  target PC for redirect.

Function
REQ-015 SHALL define dequeue = fd_valid & fd_ready; head advances at the edge.
REQ-016 SHALL define fetch = !redirect & (count<QDEPTH | dequeue); on fetch, {PC+1, q_imem} enqueued and PC <= PC+1 at the edge.
REQ-017 SHALL hold PC and enqueue nothing when full with no dequeue.
REQ-018 SHALL allow simultaneous enqueue and dequeue when full; count unchanged.
REQ-019 SHALL, on redirect, give it priority over fetch/dequeue: PC <= redirect_pc, queue emptied, no enqueue that cycle.
REQ-020 SHALL give latency: instruction fetched in cycle t appears at fd_* in cycle t+1; after redirect in cycle t, target fetched in t+1, presented in t+2.
REQ-021 SHALL wrap PC+1 modulo 2^ADDR_W, with no overflow flag.
REQ-022 SHALL keep fd_valid=0, fd_pc=0, fd_ir=0 while the queue is empty; fd_ready is ignored when empty.
REQ-023 SHALL derive fd_* only from registered queue state, with no combinational path from q_imem, fd_ready or redirect.
REQ-024 SHALL keep read/write pointers of log2(QDEPTH) bits wrapping naturally, with count of log2(QDEPTH)+1 bits.

Reset
REQ-025 SHALL on reset set PC=RESET_PC, pointers=0, count=0, fd_valid=0, fd_pc=0, fd_ir=0, counters=0.
REQ-026 SHALL discard any in-flight instruction or redirect when reset asserts mid-operation; first fetch is at RESET_PC in the first cycle after deassertion.

Configuration
REQ-027 SHALL, with FETCH_PERF_EN defined, add outputs perf_fetched (out, 32) counting fetches and perf_stalls (out, 32) counting cycles with fd_valid & !fd_ready; both wrap at 2^32.
REQ-028 SHALL, without FETCH_PERF_EN, omit those ports and counters entirely, with identical remaining behaviour.

Structure
REQ-029 SHALL place the NOP constant, the RESET_PC default and the queue-entry type {pc, ir} in shared package fetch_pkg.
REQ-030 SHALL implement the circular buffer as sub-module fetch_queue (push, pop, clear, full, empty, head); fetch_unit holds the PC and control.

Verification
REQ-031 SHALL cover: reset, fd_ready=1, imem[k]=k+100 -> cycle 1 fd_valid=1, fd_pc=1, fd_ir=100; then fd_pc=2,3,... each cycle.
REQ-032 SHALL cover: fd_ready=0 from reset, QDEPTH=2 -> after 2 fetches address_imem holds at 2; fd_pc stays 1 until fd_ready=1.
REQ-033 SHALL cover: full queue with fd_ready=1 held one cycle -> one enqueue plus one dequeue, count stays 2, PC 2->3.
REQ-034 SHALL cover: redirect=1, redirect_pc=0x40 in cycle t -> address_imem=0x40 in t+1, fd_valid=0 in t+1, fd_pc=0x41 in t+2; stale entries never appear.
REQ-035 SHALL cover: ADDR_W=4, run through PC=15 -> next fetch address 0, fd_pc of that entry =0.
REQ-036 SHALL cover: reset asserted mid-cycle with a full queue -> fd_valid falls immediately; after release, address_imem=RESET_PC; with FETCH_PERF_EN, both counters read 0.
